// File: rtl/alu_mult_sequencer.sv
// Shift-add low-half multiplier that borrows the shared EX-stage ALU one add or shift at a time.
// Latency: 2*WIDTH+1 cycles from start-accept to done (2*n+1 with EARLY_EXIT), +1 per grant-low cycle.
// Backpressure: start taken only while ready; ADD/SHIFT freeze state and hold ALU operands while alu_grant=0.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra
    } lc3b_aluop;
endpackage

module alu_mult_sequencer
    import lc3b_types::*;
#(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_req,
    input  logic             alu_grant,
    output lc3b_aluop        aluop,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_inc;
    logic [WIDTH-1:0] mplier_shr;
    logic             last_iter;

    assign count_inc  = count + CW'(1);
    assign mplier_shr = mplier >> 1;
    assign last_iter  = (count_inc == CW'(WIDTH)) ||
                        ((EARLY_EXIT != 0) && (mplier_shr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   if (alu_grant) state_nxt = S_SHIFT;
            S_SHIFT: if (alu_grant) state_nxt = last_iter ? S_DONE : S_ADD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are a pure function of state and registers, so they stay put across a stall.
    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        alu_req = 1'b0;
        aluop   = alu_pass;
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_ADD: begin
                alu_req = 1'b1;
                aluop   = alu_add;
                alu_a   = acc;
                alu_b   = mplier[0] ? mcand : '0;
            end
            S_SHIFT: begin
                alu_req = 1'b1;
                aluop   = alu_sll;
                alu_a   = mcand;
                alu_b   = WIDTH'(1);
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // product is loaded on the edge into DONE so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                S_ADD: begin
                    if (alu_grant) acc <= alu_f;
                end
                S_SHIFT: begin
                    if (alu_grant) begin
                        mcand  <= alu_f;
                        mplier <= mplier_shr;
                        count  <= count_inc;
                        if (last_iter) product <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: one instance per EARLY_EXIT setting, each wired to a behavioural ALU.
module tb_alu_mult_sequencer;
    import lc3b_types::*;

    logic        clk;
    logic        rst_w    [2];
    logic        start_w  [2];
    logic [15:0] opa_w    [2];
    logic [15:0] opb_w    [2];
    logic        ready_w  [2];
    logic        done_w   [2];
    logic [15:0] prod_w   [2];
    logic        req_w    [2];
    logic        grant_w  [2];
    lc3b_aluop   aluop_w  [2];
    logic [15:0] alu_a_w  [2];
    logic [15:0] alu_b_w  [2];
    logic [15:0] alu_f_w  [2];

    int checks     = 0;
    int errors     = 0;
    int proto_bad  = 0;
    int req_cycles = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_mult_sequencer #(.WIDTH(16), .EARLY_EXIT(gi)) u_dut (
            .clk       (clk),
            .reset     (rst_w[gi]),
            .start     (start_w[gi]),
            .op_a      (opa_w[gi]),
            .op_b      (opb_w[gi]),
            .ready     (ready_w[gi]),
            .done      (done_w[gi]),
            .product   (prod_w[gi]),
            .alu_req   (req_w[gi]),
            .alu_grant (grant_w[gi]),
            .aluop     (aluop_w[gi]),
            .alu_a     (alu_a_w[gi]),
            .alu_b     (alu_b_w[gi]),
            .alu_f     (alu_f_w[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            alu_f_w[i] = alu_a_w[i];
            case (aluop_w[i])
                alu_add: alu_f_w[i] = alu_a_w[i] + alu_b_w[i];
                alu_and: alu_f_w[i] = alu_a_w[i] & alu_b_w[i];
                alu_not: alu_f_w[i] = ~alu_a_w[i];
                alu_sll: alu_f_w[i] = alu_a_w[i] << alu_b_w[i][3:0];
                alu_srl: alu_f_w[i] = alu_a_w[i] >> alu_b_w[i][3:0];
                alu_sra: alu_f_w[i] = 16'($signed(alu_a_w[i]) >>> alu_b_w[i][3:0]);
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req_w[i] === 1'b1) begin
                req_cycles++;
                if (aluop_w[i] !== alu_add && aluop_w[i] !== alu_sll) proto_bad++;
                if (ready_w[i] !== 1'b0 || done_w[i] !== 1'b0) proto_bad++;
            end else if (req_w[i] === 1'b0) begin
                if (aluop_w[i] !== alu_pass || alu_a_w[i] !== 16'h0 || alu_b_w[i] !== 16'h0)
                    proto_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ALU steps needed: one add and one shift per multiplier bit consumed.
    function automatic int steps(input int d, input logic [15:0] b);
        int n;
        n = 16;
        if (d == 1) begin
            n = 1;
            for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        end
        return 2 * n;
    endfunction

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input int stall_from, input int stall_len, input bit rnd,
                          input bit poke, input int lit_lat, input string tag);
        logic [15:0] prev;
        logic [15:0] exp_p;
        int          work, done_at, exp_done, rdy_bad, hold_bad, stall_bad, extra;
        bit          g, busy, prev_stall;
        lc3b_aluop   s_op;
        logic [15:0] s_a, s_b;
        prev       = prod_w[d];
        exp_p      = 16'(32'(a) * 32'(b));
        work       = steps(d, b);
        done_at    = -1;
        exp_done   = -1;
        rdy_bad    = 0;
        hold_bad   = 0;
        stall_bad  = 0;
        extra      = 0;
        prev_stall = 1'b0;
        s_op       = alu_pass;
        s_a        = '0;
        s_b        = '0;
        check({tag, "_ready_before"}, 32'(ready_w[d]), 32'd1);
        opa_w[d]   = a;
        opb_w[d]   = b;
        start_w[d] = 1'b1;
        @(posedge clk); #1;
        start_w[d] = 1'b0;
        opa_w[d]   = 16'($urandom);
        opb_w[d]   = 16'($urandom);
        for (int k = 1; k <= 400; k++) begin
            if (done_w[d] === 1'b1) begin
                if (done_at < 0) done_at = k;
                else extra++;
            end
            if (done_at < 0) begin
                if (ready_w[d] !== 1'b0) rdy_bad++;
                if (prod_w[d] !== prev) hold_bad++;
            end
            if (k == done_at) begin
                check({tag, "_product"}, 32'(prod_w[d]), 32'(exp_p));
                check({tag, "_ready_at_done"}, 32'(ready_w[d]), 32'd0);
            end
            if (done_at > 0 && k == done_at + 1) begin
                check({tag, "_ready_after"}, 32'(ready_w[d]), 32'd1);
                check({tag, "_done_pulse"}, 32'(done_w[d]), 32'd0);
                break;
            end
            g    = 1'b1;
            busy = (work > 0);
            if (busy) begin
                if (k >= stall_from && k < stall_from + stall_len) g = 1'b0;
                if (rnd && $urandom_range(0, 3) == 0) g = 1'b0;
                if (!g) begin
                    if (req_w[d] !== 1'b1) stall_bad++;
                    if (prev_stall && (aluop_w[d] !== s_op || alu_a_w[d] !== s_a ||
                                       alu_b_w[d] !== s_b)) stall_bad++;
                    s_op = aluop_w[d];
                    s_a  = alu_a_w[d];
                    s_b  = alu_b_w[d];
                end else begin
                    work--;
                    if (work == 0) exp_done = k + 1;
                end
            end
            prev_stall = !g;
            grant_w[d] = g;
            start_w[d] = poke && busy && (k == 3 || k == 6);
            if (start_w[d]) begin
                opa_w[d] = ~a;
                opb_w[d] = b + 16'd1;
            end
            @(posedge clk); #1;
        end
        grant_w[d] = 1'b1;
        start_w[d] = 1'b0;
        check({tag, "_latency"}, 32'(done_at), 32'(exp_done));
        if (lit_lat > 0) check({tag, "_latency_plan"}, 32'(done_at), 32'(lit_lat));
        check({tag, "_ready_low_busy"}, 32'(rdy_bad), 32'd0);
        check({tag, "_product_held"}, 32'(hold_bad), 32'd0);
        check({tag, "_stall_stable"}, 32'(stall_bad), 32'd0);
        check({tag, "_extra_done"}, 32'(extra), 32'd0);
    endtask

    task automatic reset_mid(input int d);
        int dn;
        dn         = 0;
        opa_w[d]   = 16'd3;
        opb_w[d]   = 16'd5;
        start_w[d] = 1'b1;
        @(posedge clk); #1;
        start_w[d] = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (done_w[d] === 1'b1) dn++;
            if (k == 10) rst_w[d] = 1'b1;
            if (k == 11) begin
                check("rstmid_ready", 32'(ready_w[d]), 32'd1);
                check("rstmid_product", 32'(prod_w[d]), 32'd0);
                check("rstmid_req", 32'(req_w[d]), 32'd0);
                rst_w[d] = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("rstmid_no_done", 32'(dn), 32'd0);
        check("rstmid_idle", 32'(ready_w[d]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        int          rd;
        for (int i = 0; i < 2; i++) begin
            rst_w[i]   = 1'b1;
            start_w[i] = 1'b0;
            grant_w[i] = 1'b1;
            opa_w[i]   = '0;
            opb_w[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", 32'(ready_w[i]), 32'd1);
            check("reset_done", 32'(done_w[i]), 32'd0);
            check("reset_product", 32'(prod_w[i]), 32'd0);
            check("reset_req", 32'(req_w[i]), 32'd0);
            check("reset_aluop", 32'(aluop_w[i]), 32'(alu_pass));
            rst_w[i] = 1'b0;
        end

        run_op(0, 16'd3, 16'd5, 0, 0, 1'b0, 1'b0, 33, "m3x5");
        run_op(0, 16'hFFFF, 16'hFFFF, 0, 0, 1'b0, 1'b0, 33, "mffff");
        run_op(0, 16'd300, 16'd300, 0, 0, 1'b0, 1'b0, 33, "m300");
        run_op(0, 16'd3, 16'd5, 8, 5, 1'b0, 1'b0, 38, "stall");
        run_op(1, 16'd7, 16'd4, 0, 0, 1'b0, 1'b0, 7, "ee7x4");
        run_op(1, 16'd9, 16'd0, 0, 0, 1'b0, 1'b0, 3, "ee9x0");
        run_op(1, 16'd2, 16'h8000, 0, 0, 1'b0, 1'b0, 33, "ee2x8000");

        for (int t = 0; t < 24; t++) begin
            rd = int'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            run_op(rd, ra, rb, 0, 0, 1'b1, 1'b0, 0, "rnd");
        end

        run_op(0, 16'h1234, 16'h0ABC, 0, 0, 1'b0, 1'b1, 33, "poke");
        reset_mid(0);

        check("proto_alu_use", 32'(proto_bad), 32'd0);
        check("proto_req_seen", 32'(req_cycles != 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit low-half product (a × b mod 2^WIDTH) by sequencing shift-add operations through the shared datapath ALU. The ALU itself is not instantiated here.
- Sits beside the EX stage. It requests the ALU, drives aluop/a/b while granted, and captures f. It stalls cleanly whenever the ALU is granted elsewhere.
- The low half is identical for signed and unsigned operands, so there is no sign handling.

Parameters:
- WIDTH, 16, operand/result width; must equal lc3b_word width.
- EARLY_EXIT, 0, when 1, terminate once the remaining multiplier bits are all zero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when ready=1.
- op_a  input  WIDTH  multiplicand; latched on accepted start.
- op_b  input  WIDTH  multiplier; latched on accepted start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; product valid.
- product  output  WIDTH  result register; holds until next accepted start.
- alu_req  output  1  high in ADD and SHIFT states.
- alu_grant  input  1  ALU owned by this block this cycle.
- aluop  output  lc3b_aluop  ALU operation.
- alu_a  output  WIDTH  ALU a operand.
- alu_b  output  WIDTH  ALU b operand.
- alu_f  input  WIDTH  ALU result, combinational from aluop/alu_a/alu_b.

Behaviour:
- Internal registers:
  - mcand (WIDTH), mplier (WIDTH), acc (WIDTH).
  - iteration count (clog2(WIDTH)+1 bits).
  - state, one of IDLE, ADD, SHIFT, DONE.
- Reset (synchronous):
  - state=IDLE; acc, mcand, mplier, count, product = 0.
  - done=0, alu_req=0, aluop=alu_pass, alu_a=alu_b=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- IDLE:
  - ready=1.
  - On start: mcand←op_a, mplier←op_b, acc←0, count←0, next state ADD.
  - start while not in IDLE is ignored; no queuing.
- ADD:
  - Drives aluop=alu_add, alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - If granted: acc←alu_f, next state SHIFT.
  - The add happens even when mplier[0]=0 (adds 0), keeping latency data-independent.
- SHIFT:
  - Drives aluop=alu_sll, alu_a=mcand, alu_b=1.
  - If granted: mcand←alu_f, mplier←mplier>>1 (local logical shift), count←count+1.
  - Next state is DONE if count+1==WIDTH, or if EARLY_EXIT=1 and (mplier>>1)==0. Otherwise next state is ADD.
- Stall:
  - In ADD/SHIFT with alu_grant=0, no register changes and the state is held.
  - aluop/alu_a/alu_b remain driven, so the operands stay stable for a later grant.
- DONE:
  - product←acc, done=1 for exactly one cycle.
  - Next state IDLE. ready=0 during DONE.
- Outputs outside ADD/SHIFT: alu_req=0, aluop=alu_pass, alu_a=alu_b=0.
- Arithmetic: all sums truncate mod 2^WIDTH; overflow is discarded silently.
- Latency, measured from the start-accept edge (cycle 0) with continuous grant:
  - EARLY_EXIT=0: done at cycle 2·WIDTH+1, i.e. 33 for WIDTH=16; ready again at cycle 34.
  - EARLY_EXIT=1: done at cycle 2·n+1, where n = max(1, index of highest set bit of op_b + 1).
  - Each grant-low cycle in ADD/SHIFT adds exactly one cycle.
- A new start accepted at the first ready cycle after done is legal. product changes only at the next DONE.

Test Plan:
- Reset, then op_a=3, op_b=5, start, grant tied high, EARLY_EXIT=0 -> done at cycle 33, product=0x000F. ready=0 during cycles 1–33 and ready=1 at cycle 34.
- op_a=0xFFFF, op_b=0xFFFF -> product=0x0001. Then op_a=300, op_b=300 back-to-back -> product=0x5F90, with 0x0001 held until the second done.
- 3×5 with alu_grant deasserted for 5 cycles during the 4th SHIFT -> done at cycle 38, product=0x000F. aluop/alu_a/alu_b stay constant throughout the stall; alu_req stays high.
- EARLY_EXIT=1 -> the cases below, each with correct product:
  - 7×4: done at cycle 7, product=0x001C.
  - 9×0: done at cycle 3, product=0x0000.
  - 2×0x8000: done at cycle 33, product=0x0000.
- start pulsed during ADD/SHIFT with different operands -> ignored, and the original result is produced. reset asserted at cycle 10 -> next cycle state IDLE, ready=1, product=0, no done pulse.
- ALU model driving alu_f from aluop -> every cycle with alu_req=1 uses only alu_add or alu_sll; alu_req=0 in IDLE/DONE.
